// File: rtl/key_search_ctrl_if.sv
// Handshake and RAM-read bundle between the key search controller and the
// RC4 pipeline / decrypted-message RAM. master = controller side.
interface key_search_ctrl_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic              decrypt_done;
  logic [7:0]        rd_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       secret_key;
  logic              pipe_start;
  logic              busy;
  logic              found;
  logic              exhausted;

  modport master (
    input  start, decrypt_done, rd_q,
    output rd_addr, secret_key, pipe_start, busy, found, exhausted
  );

  modport slave (
    output start, decrypt_done, rd_q,
    input  rd_addr, secret_key, pipe_start, busy, found, exhausted
  );
endinterface

// File: rtl/key_search_ctrl.sv
// Brute-force key search: after each decrypt pass, scan the message RAM for
// lowercase/space only; on success stop, otherwise bump the key and relaunch.
// All outputs are registered from next-state values so they change on the
// same edge as the state they belong to.
module key_search_ctrl #(
  parameter int          MSG_LEN   = 32,
  parameter logic [23:0] KEY_START = 24'h000000,
  parameter logic [23:0] KEY_MAX   = 24'h3FFFFF
) (
  input logic             clk,
  input logic             reset_n,
  key_search_ctrl_if.master ks
);
  localparam int          AW   = 5;
  localparam logic [AW-1:0] LAST = AW'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LAUNCH, S_WAIT_DEC, S_RD_ADDR, S_RD_WAIT,
    S_CHECK, S_NEXT_KEY, S_FOUND, S_EXHAUSTED
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] idx, idx_nx;
  logic [23:0]   key, key_nx;
  logic [AW-1:0] rd_addr_q;
  logic          pipe_start_q, busy_q, found_q, exhausted_q;
  logic          byte_ok;

  // Accept space or 'a'..'z'; anything else aborts the pass.
  always_comb begin
    byte_ok = (ks.rd_q == 8'h20) || ((ks.rd_q >= 8'h61) && (ks.rd_q <= 8'h7A));
  end

  // Next-state, byte index and candidate key.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    key_nx   = key;
    case (state)
      S_IDLE: begin
        if (ks.start) begin
          key_nx   = KEY_START;
          state_nx = S_LAUNCH;
        end
      end
      S_LAUNCH:   state_nx = S_WAIT_DEC;
      S_WAIT_DEC: begin
        if (ks.decrypt_done) begin
          idx_nx   = '0;
          state_nx = S_RD_ADDR;
        end
      end
      // Two cycles of address hold cover the registered-address RAM latency.
      S_RD_ADDR: state_nx = S_RD_WAIT;
      S_RD_WAIT: state_nx = S_CHECK;
      S_CHECK: begin
        if (!byte_ok)          state_nx = S_NEXT_KEY;
        else if (idx == LAST)  state_nx = S_FOUND;
        else begin
          idx_nx   = idx + 1'b1;
          state_nx = S_RD_ADDR;
        end
      end
      S_NEXT_KEY: begin
        // Saturate at the top of the range rather than wrapping.
        if (key >= KEY_MAX) begin
          key_nx   = KEY_MAX;
          state_nx = S_EXHAUSTED;
        end else begin
          key_nx   = key + 24'd1;
          state_nx = S_LAUNCH;
        end
      end
      S_FOUND, S_EXHAUSTED: begin
        if (ks.start) begin
          key_nx   = KEY_START;
          state_nx = S_LAUNCH;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State and registered outputs, all derived from next-state values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      key          <= '0;
      rd_addr_q    <= '0;
      pipe_start_q <= 1'b0;
      busy_q       <= 1'b0;
      found_q      <= 1'b0;
      exhausted_q  <= 1'b0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      key          <= key_nx;
      rd_addr_q    <= idx_nx;
      pipe_start_q <= (state_nx == S_LAUNCH);
      busy_q       <= (state_nx == S_LAUNCH)  || (state_nx == S_WAIT_DEC) ||
                      (state_nx == S_RD_ADDR) || (state_nx == S_RD_WAIT)  ||
                      (state_nx == S_CHECK)   || (state_nx == S_NEXT_KEY);
      found_q      <= (state_nx == S_FOUND);
      exhausted_q  <= (state_nx == S_EXHAUSTED);
    end
  end

  assign ks.rd_addr    = rd_addr_q;
  assign ks.secret_key = key;
  assign ks.pipe_start = pipe_start_q;
  assign ks.busy       = busy_q;
  assign ks.found      = found_q;
  assign ks.exhausted  = exhausted_q;
endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed bench for key_search_ctrl: two instances (default range and a
// range starting at 24'h3FFFFE), behavioural registered-address RAM model.
module tb_key_search_ctrl;
  logic clk, reset_n;
  int   checks = 0;
  int   fails  = 0;
  int   mode;
  logic [7:0] bad_byte;
  int   ps_cnt = 0, ps_cnt2 = 0;
  int   base;

  key_search_ctrl_if #(.ADDR_W(5)) a_if ();
  key_search_ctrl_if #(.ADDR_W(5)) b_if ();

  key_search_ctrl u_dut (.clk(clk), .reset_n(reset_n), .ks(a_if.master));
  key_search_ctrl #(.KEY_START(24'h3FFFFE)) u_dut2 (.clk(clk), .reset_n(reset_n), .ks(b_if.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Message contents as a function of candidate key and address.
  function automatic logic [7:0] msg_byte(input logic [23:0] key, input logic [4:0] addr);
    case (mode)
      0: msg_byte = 8'h61;
      1: msg_byte = (key == 24'd0) ? ((addr == 5'd5) ? 8'h41 : 8'h61) : 8'h20;
      2: msg_byte = (addr == 5'd0) ? bad_byte : 8'h61;
      default: msg_byte = 8'h00;
    endcase
  endfunction

  // Registered-address RAM: data appears the cycle after the address is sampled.
  always @(posedge clk) begin
    a_if.rd_q <= msg_byte(a_if.secret_key, a_if.rd_addr);
    b_if.rd_q <= 8'h00;
  end

  always @(posedge clk) begin
    if (a_if.pipe_start) ps_cnt  <= ps_cnt + 1;
    if (b_if.pipe_start) ps_cnt2 <= ps_cnt2 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    a_if.start = 1'b1; tick(); a_if.start = 1'b0;
  endtask

  task automatic pulse_dd();
    a_if.decrypt_done = 1'b1; tick(); a_if.decrypt_done = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".rd_addr"},    {27'd0, a_if.rd_addr}, 32'd0);
    chk({tag, ".key"},        {8'd0, a_if.secret_key}, 32'd0);
    chk({tag, ".pipe_start"}, {31'd0, a_if.pipe_start}, 32'd0);
    chk({tag, ".busy"},       {31'd0, a_if.busy}, 32'd0);
    chk({tag, ".found"},      {31'd0, a_if.found}, 32'd0);
    chk({tag, ".exhausted"},  {31'd0, a_if.exhausted}, 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; #1;
    chk_zero("rst_async");
    tick(); reset_n = 1'b1; tick();
  endtask

  // Walk a full passing scan, checking the address held for 3 cycles per byte.
  task automatic scan_all(input string tag);
    for (int k = 0; k < 32; k++)
      for (int j = 0; j < 3; j++) begin
        chk(tag, {27'd0, a_if.rd_addr}, k);
        tick();
      end
  endtask

  logic [7:0] bvals [7] = '{8'h1F, 8'h21, 8'h60, 8'h7B, 8'h20, 8'h61, 8'h7A};
  logic       bpass [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    mode = 0; bad_byte = 8'h00;
    reset_n = 1'b0;
    a_if.start = 1'b0; a_if.decrypt_done = 1'b0;
    b_if.start = 1'b0; b_if.decrypt_done = 1'b0;

    // Reset held with random stimulus, then release: stays idle.
    for (int i = 0; i < 4; i++) begin
      a_if.start = 1'($urandom); a_if.decrypt_done = 1'($urandom);
      tick();
      chk_zero("reset_hold");
    end
    a_if.start = 1'b0; a_if.decrypt_done = 1'b0;
    reset_n = 1'b1;
    tick(3);
    chk_zero("reset_release");

    // Stray decrypt_done in IDLE.
    pulse_dd(); tick(2);
    chk_zero("idle_dd");

    // Immediate hit.
    mode = 0; base = ps_cnt;
    pulse_start();
    chk("hit.pipe_start", {31'd0, a_if.pipe_start}, 1);
    chk("hit.busy",       {31'd0, a_if.busy}, 1);
    tick();
    chk("hit.pipe_start_1cyc", {31'd0, a_if.pipe_start}, 0);
    tick(2);
    pulse_dd();
    scan_all("hit.addr");
    chk("hit.found", {31'd0, a_if.found}, 1);
    chk("hit.busy0", {31'd0, a_if.busy}, 0);
    chk("hit.key",   {8'd0, a_if.secret_key}, 0);
    chk("hit.npulse", ps_cnt - base, 1);

    // Early abort on key 0 byte 5, hit on key 1 (relaunched from FOUND).
    mode = 1; base = ps_cnt;
    pulse_start();
    chk("abort.key0", {8'd0, a_if.secret_key}, 0);
    tick(3);
    pulse_dd();
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < 3; j++) begin
        chk("abort.addr", {27'd0, a_if.rd_addr}, k);
        tick();
      end
    chk("abort.nk_busy",  {31'd0, a_if.busy}, 1);
    chk("abort.nk_ps",    {31'd0, a_if.pipe_start}, 0);
    chk("abort.nk_addr",  {27'd0, a_if.rd_addr}, 5);
    tick();
    chk("abort.relaunch", {31'd0, a_if.pipe_start}, 1);
    chk("abort.key1",     {8'd0, a_if.secret_key}, 1);
    chk("abort.noaddr6",  {27'd0, a_if.rd_addr}, 5);
    tick(2);
    pulse_dd();
    scan_all("abort.addr2");
    chk("abort.found", {31'd0, a_if.found}, 1);
    chk("abort.keyf",  {8'd0, a_if.secret_key}, 1);
    chk("abort.npulse", ps_cnt - base, 2);

    // Boundary characters at byte 0.
    mode = 2;
    for (int i = 0; i < 7; i++) begin
      do_reset();
      bad_byte = bvals[i];
      pulse_start(); tick(2);
      pulse_dd(); tick(3);
      chk($sformatf("bnd_%0h.addr", bvals[i]), {27'd0, a_if.rd_addr}, bpass[i] ? 1 : 0);
      chk($sformatf("bnd_%0h.busy", bvals[i]), {31'd0, a_if.busy}, 1);
      tick();
      chk($sformatf("bnd_%0h.ps", bvals[i]), {31'd0, a_if.pipe_start}, bpass[i] ? 0 : 1);
      chk($sformatf("bnd_%0h.key", bvals[i]), {8'd0, a_if.secret_key}, bpass[i] ? 0 : 1);
    end

    // Start ignored in WAIT_DEC, then reset during CHECK.
    do_reset();
    mode = 0; base = ps_cnt;
    pulse_start(); tick();
    pulse_start();
    chk("wd.start_ign_ps",   {31'd0, a_if.pipe_start}, 0);
    chk("wd.start_ign_busy", {31'd0, a_if.busy}, 1);
    tick();
    pulse_dd(); tick(5);
    chk("midrst.pre_addr", {27'd0, a_if.rd_addr}, 1);
    chk("midrst.npulse", ps_cnt - base, 1);
    reset_n = 1'b0; #1;
    chk_zero("midrst");
    tick(); reset_n = 1'b1; tick(2);
    chk_zero("midrst_rel");

    // Exhaustion on the second instance: 3FFFFE, 3FFFFF, then stop.
    base = ps_cnt2;
    b_if.start = 1'b1; tick(); b_if.start = 1'b0;
    chk("exh.key0", {8'd0, b_if.secret_key}, 32'h3FFFFE);
    tick(2);
    b_if.decrypt_done = 1'b1; tick(); b_if.decrypt_done = 1'b0;
    tick(4);
    chk("exh.ps2", {31'd0, b_if.pipe_start}, 1);
    chk("exh.key1", {8'd0, b_if.secret_key}, 32'h3FFFFF);
    tick(2);
    b_if.decrypt_done = 1'b1; tick(); b_if.decrypt_done = 1'b0;
    tick(4);
    chk("exh.flag", {31'd0, b_if.exhausted}, 1);
    chk("exh.busy", {31'd0, b_if.busy}, 0);
    chk("exh.keyh", {8'd0, b_if.secret_key}, 32'h3FFFFF);
    tick(2);
    chk("exh.npulse", ps_cnt2 - base, 2);
    chk("exh.hold",   {8'd0, b_if.secret_key}, 32'h3FFFFF);
    b_if.start = 1'b1; tick(); b_if.start = 1'b0;
    chk("exh.restart_ps",  {31'd0, b_if.pipe_start}, 1);
    chk("exh.restart_key", {8'd0, b_if.secret_key}, 32'h3FFFFE);
    chk("exh.restart_flag", {31'd0, b_if.exhausted}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/key_search_ctrl.md
# key_search_ctrl

Brute-force key search controller that sits downstream of the RC4 decrypt stage. It reads the 32-byte decrypted message RAM after each decrypt pass and checks that every byte is lowercase ASCII or space. If the message passes, it stops and reports the key. If not, it increments the 24-bit secret key and relaunches the init/shuffle/decrypt pipeline. It drives `secret_key` and the pipeline start pulse in place of the constant key and push-button start.

## Interface

Parameters:
- `MSG_LEN`, 32: number of message bytes checked; address width is 5.
- `KEY_START`, 24'h000000: first candidate key.
- `KEY_MAX`, 24'h3FFFFF: last candidate key; the upper 2 key bits are always 0.

Ports:
- `clk`  in  1  system clock (CLOCK_50); all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a search from `KEY_START`.
- `decrypt_done`  in  1  one-cycle pulse from the decrypt stage; all `MSG_LEN` bytes have been written.
- `rd_q`  in  8  decrypted-message RAM read data.
- `rd_addr`  out  5  decrypted-message RAM read address.
- `secret_key`  out  24  current candidate key, held stable while the pipeline runs.
- `pipe_start`  out  1  one-cycle pulse that restarts the init/shuffle/decrypt stages with `secret_key`.
- `busy`  out  1  high from search launch until FOUND or EXHAUSTED.
- `found`  out  1  high while in FOUND; `secret_key` is the valid key.
- `exhausted`  out  1  high while in EXHAUSTED; no key in range produced a valid message.

## Operation

Byte validity rule: a byte is valid iff it equals 8'h20 or lies in 8'h61..8'h7A inclusive.

State machine:
- **IDLE**: all outputs 0.
  - `start` → set `secret_key`=`KEY_START`, go to LAUNCH.
- **LAUNCH**: `pipe_start`=1 for exactly this cycle; go to WAIT_DEC.
- **WAIT_DEC**: wait for `decrypt_done`. On it, set idx=0 and go to RD_ADDR.
- **RD_ADDR**: drive `rd_addr`=idx; go to RD_WAIT.
- **RD_WAIT**: hold `rd_addr`; go to CHECK.
- **CHECK**: hold `rd_addr`; sample `rd_q`.
  - Invalid byte → NEXT_KEY (early abort; remaining bytes are not read).
  - Valid and idx==`MSG_LEN`-1 → FOUND.
  - Otherwise → idx+1, RD_ADDR.
- **NEXT_KEY**:
  - `secret_key`==`KEY_MAX` → EXHAUSTED; key is held, not wrapped.
  - Otherwise → `secret_key`+1, LAUNCH.
- **FOUND**: `found`=1, `busy`=0, `secret_key` held. `start` → reload `KEY_START`, LAUNCH.
- **EXHAUSTED**: `exhausted`=1, `busy`=0, `secret_key`=`KEY_MAX`. `start` → reload `KEY_START`, LAUNCH.

Rules and boundary conditions:
- `busy`=1 in LAUNCH, WAIT_DEC, RD_ADDR, RD_WAIT, CHECK, NEXT_KEY.
- `start` while `busy` is ignored.
- `decrypt_done` outside WAIT_DEC is ignored.
- `start` and `decrypt_done` in the same cycle follow the rules for the current state only.
- idx is a 5-bit counter and never wraps within a pass.
- Key increment is 24-bit unsigned. Only values in `KEY_START`..`KEY_MAX` are ever driven.
- Reset asserted in any state → IDLE immediately. `secret_key`, `rd_addr`, idx=0. All flags 0. No `pipe_start` pulse is emitted on reset release.

## Timing

- Reset values: `rd_addr`=0, `secret_key`=0, `pipe_start`=0, `busy`=0, `found`=0, `exhausted`=0.
- All outputs are registered.
- `start` sampled at edge t → `pipe_start` high during cycle t+1. `busy` rises at the same edge as LAUNCH entry.
- RAM contract: registered address. `rd_addr` driven in cycle n is sampled by the RAM at the end of n; `rd_q` is sampled by this block at the end of n+2 (CHECK).
- Per byte: 3 cycles. A full passing check of 32 bytes takes 96 cycles after the `decrypt_done` edge.
- Failing pass: CHECK → NEXT_KEY → LAUNCH, so `pipe_start` re-pulses 2 cycles after the failing CHECK edge.
- `found`/`exhausted` assert on the edge leaving CHECK/NEXT_KEY, and `busy` deasserts on that same edge.

## Test plan

- **Reset**: hold `reset_n`=0 with random inputs → all outputs 0. Release → still IDLE, no `pipe_start`.
- **Immediate hit**: `start`, then a RAM model of 32×8'h61, then `decrypt_done` → exactly one `pipe_start`, 32 reads at addr 0..31, `found`=1, `secret_key`=0, `busy`=0.
- **Early abort then hit**: for key 0, byte 5 = 8'h41; key 1 is all 8'h20 → key 0 pass reads addr 0..5 only; second `pipe_start` with `secret_key`=1; final `found`=1, `secret_key`=1.
- **Boundary chars**: single-byte-varied messages. Bytes 8'h1F, 8'h21, 8'h60, 8'h7B each fail. Bytes 8'h20, 8'h61, 8'h7A each pass.
- **Exhaustion**: `KEY_START`=24'h3FFFFE, all messages contain 8'h00 → 2 `pipe_start` pulses, `exhausted`=1, `secret_key`=24'h3FFFFF. A later `start` relaunches at 24'h3FFFFE.
- **Mid-operation reset / stray inputs**: `decrypt_done` in IDLE → no reads. `start` during WAIT_DEC → ignored. `reset_n` low during CHECK → IDLE with all outputs 0 on the next sample.
